// File: rtl/energy_pkg.sv
// Shared types for the powertrain mode sequencer.
//   mode_req_e  : decoded/committed operating-mode request
//   seq_state_e : sequencer FSM states
//   AM_*        : active_mode output encoding
//   state_am()  : maps an FSM state to its active_mode code
package energy_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ELEC,
      HYB,
      REGEN,
      INVALID
   } mode_req_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEAD,
      S_ELEC,
      S_CRANK,
      S_HYBRID,
      S_REGEN,
      S_FAULT
   } seq_state_e;

   localparam logic [1:0] AM_IDLE  = 2'd0;
   localparam logic [1:0] AM_ELEC  = 2'd1;
   localparam logic [1:0] AM_HYB   = 2'd2;
   localparam logic [1:0] AM_REGEN = 2'd3;

   // Crank already reports hybrid so the controller sees the mode it asked for.
   function automatic logic [1:0] state_am(input seq_state_e s);
      case (s)
         S_ELEC:            return AM_ELEC;
         S_CRANK, S_HYBRID: return AM_HYB;
         S_REGEN:           return AM_REGEN;
         default:           return AM_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/mode_input_filter.sv
// Decodes the one-hot operating-mode lines and debounces the result.
//   clk, reset_n              : clock, async active-low reset
//   operating_mode0/1/2       : raw electric / hybrid / regen request lines
//   committed                 : request held stable for STABLE_CYCLES samples
module mode_input_filter
   import energy_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic      clk,
   input  logic      reset_n,
   input  logic      operating_mode0,
   input  logic      operating_mode1,
   input  logic      operating_mode2,
   output mode_req_e committed
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   mode_req_e     dec;
   mode_req_e     req_q;
   logic [CW-1:0] cnt;

   always_comb begin
      dec = INVALID;
      case ({operating_mode2, operating_mode1, operating_mode0})
         3'b000:  dec = IDLE;
         3'b001:  dec = ELEC;
         3'b010:  dec = HYB;
         3'b100:  dec = REGEN;
         default: dec = INVALID;
      endcase
   end

   // cnt holds how many consecutive samples req_q has seen; a new value
   // restarts it at 1 because the edge that loads it is its first sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_q     <= IDLE;
         cnt       <= '0;
         committed <= IDLE;
      end else begin
         req_q <= dec;
         if (dec != req_q)
            cnt <= CW'(1);
         else if (cnt != CW'(STABLE_CYCLES))
            cnt <= cnt + CW'(1);
         if (dec == req_q && cnt >= CW'(STABLE_CYCLES - 1))
            committed <= req_q;
      end
   end

endmodule

// File: rtl/powertrain_mode_sequencer.sv
// Powertrain mode sequencer: filters the energy controller's mode request,
// sequences actuators with dead-time and engine crank handshake, and keeps
// a battery state-of-charge estimate.
//   clk, reset_n                 : clock, async active-low reset
//   operating_mode0/1/2          : electric / hybrid / regen request (one-hot)
//   engine_ready                 : engine running feedback
//   motor_en, engine_start,
//   engine_run, regen_en         : actuator commands
//   fault                        : sequencer is in fault state
//   active_mode                  : 0 idle, 1 electric, 2 hybrid, 3 regen
//   soc, battery_ok              : SOC estimate and hysteretic health flag
module powertrain_mode_sequencer
   import energy_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int DEAD_TIME     = 2,
   parameter int CRANK_TIMEOUT = 16,
   parameter int SOC_W         = 8,
   parameter int SOC_INIT      = 200,
   parameter int SOC_MAX       = 255,
   parameter int SOC_LOW       = 64,
   parameter int SOC_HYST      = 16,
   parameter int SOC_DIV       = 4,
   parameter int DRAIN_STEP    = 1,
   parameter int CHARGE_STEP   = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             operating_mode0,
   input  logic             operating_mode1,
   input  logic             operating_mode2,
   input  logic             engine_ready,
   output logic             motor_en,
   output logic             engine_start,
   output logic             engine_run,
   output logic             regen_en,
   output logic             fault,
   output logic [1:0]       active_mode,
   output logic [SOC_W-1:0] soc,
   output logic             battery_ok
);

   localparam int DW  = $clog2(DEAD_TIME + 1);
   localparam int KW  = $clog2(CRANK_TIMEOUT + 1);
   localparam int VW  = $clog2(SOC_DIV + 1);
   localparam int SW1 = SOC_W + 1;

   mode_req_e        committed;
   mode_req_e        eff;
   seq_state_e       state, nxt;
   logic             elec_lock, lock_nxt;
   logic [DW-1:0]    dead_cnt;
   logic [KW-1:0]    crank_cnt;
   logic [VW-1:0]    div_cnt;
   logic             tick;
   logic [SOC_W:0]   soc_diff, soc_sum;
   logic [SOC_W-1:0] soc_nxt;

   mode_input_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
      .clk             (clk),
      .reset_n         (reset_n),
      .operating_mode0 (operating_mode0),
      .operating_mode1 (operating_mode1),
      .operating_mode2 (operating_mode2),
      .committed       (committed)
   );

   // After a flat-battery drop-out, a still-held electric request is seen
   // as idle until the request moves away from electric.
   assign eff = (elec_lock && committed == ELEC) ? IDLE : committed;

   always_comb begin
      nxt      = state;
      lock_nxt = elec_lock;
      if (committed != ELEC)
         lock_nxt = 1'b0;
      if (eff == INVALID) begin
         nxt = S_FAULT;
      end else begin
         case (state)
            S_IDLE:   if (eff != IDLE) nxt = S_DEAD;
            S_REGEN:  if (eff != REGEN) nxt = S_DEAD;
            S_ELEC: begin
               if (soc == '0) begin
                  nxt      = S_DEAD;
                  lock_nxt = 1'b1;
               end else if (eff != ELEC) begin
                  nxt = S_DEAD;
               end
            end
            S_CRANK: begin
               if (eff != HYB)                                 nxt = S_DEAD;
               else if (engine_ready)                          nxt = S_HYBRID;
               else if (crank_cnt == KW'(CRANK_TIMEOUT - 1))   nxt = S_FAULT;
            end
            S_HYBRID: begin
               if (eff != HYB)         nxt = S_DEAD;
               else if (!engine_ready) nxt = S_FAULT;
            end
            // Target is taken from the request at the end of dead time.
            S_DEAD: begin
               if (dead_cnt == DW'(DEAD_TIME - 1)) begin
                  case (eff)
                     ELEC:    nxt = S_ELEC;
                     HYB:     nxt = S_CRANK;
                     REGEN:   nxt = S_REGEN;
                     default: nxt = S_IDLE;
                  endcase
               end
            end
            S_FAULT:  if (eff == IDLE) nxt = S_DEAD;
            default:  nxt = S_FAULT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         elec_lock    <= 1'b0;
         dead_cnt     <= '0;
         crank_cnt    <= '0;
         motor_en     <= 1'b0;
         engine_start <= 1'b0;
         engine_run   <= 1'b0;
         regen_en     <= 1'b0;
         fault        <= 1'b0;
         active_mode  <= AM_IDLE;
      end else begin
         state        <= nxt;
         elec_lock    <= lock_nxt;
         dead_cnt     <= (state == S_DEAD)  ? dead_cnt + DW'(1)  : '0;
         crank_cnt    <= (state == S_CRANK) ? crank_cnt + KW'(1) : '0;
         motor_en     <= (nxt == S_ELEC) || (nxt == S_HYBRID);
         engine_start <= (nxt == S_CRANK);
         engine_run   <= (nxt == S_HYBRID);
         regen_en     <= (nxt == S_REGEN);
         fault        <= (nxt == S_FAULT);
         active_mode  <= state_am(nxt);
      end
   end

   assign tick = (div_cnt == VW'(SOC_DIV - 1));

   // One extra bit catches both underflow (borrow) and overflow before clamping.
   always_comb begin
      soc_diff = {1'b0, soc} - SW1'(DRAIN_STEP);
      soc_sum  = {1'b0, soc} + SW1'(CHARGE_STEP);
      soc_nxt  = soc;
      if (tick && state == S_ELEC)
         soc_nxt = soc_diff[SOC_W] ? '0 : soc_diff[SOC_W-1:0];
      else if (tick && state == S_REGEN)
         soc_nxt = (soc_sum > SW1'(SOC_MAX)) ? SOC_W'(SOC_MAX) : soc_sum[SOC_W-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt    <= '0;
         soc        <= SOC_W'(SOC_INIT);
         battery_ok <= 1'b1;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + VW'(1);
         soc     <= soc_nxt;
         if (soc < SOC_W'(SOC_LOW))
            battery_ok <= 1'b0;
         else if ({1'b0, soc} >= SW1'(SOC_LOW + SOC_HYST))
            battery_ok <= 1'b1;
      end
   end

endmodule

// File: tb/tb_powertrain_mode_sequencer.sv
// Directed bench for powertrain_mode_sequencer. Stimulus pushes expected
// output snapshots (keyed by clock-edge number) into a scoreboard queue;
// the monitor compares them on the falling edge of the matching cycle.
module tb_powertrain_mode_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       m0 = 1'b0, m1 = 1'b0, m2 = 1'b0, rdy = 1'b0;
   logic       motor_en, engine_start, engine_run, regen_en, fault, battery_ok;
   logic [1:0] active_mode;
   logic [7:0] soc;

   powertrain_mode_sequencer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .operating_mode0 (m0),
      .operating_mode1 (m1),
      .operating_mode2 (m2),
      .engine_ready    (rdy),
      .motor_en        (motor_en),
      .engine_start    (engine_start),
      .engine_run      (engine_run),
      .regen_en        (regen_en),
      .fault           (fault),
      .active_mode     (active_mode),
      .soc             (soc),
      .battery_ok      (battery_ok)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      string       nm;
      logic [15:0] mask;
      logic [15:0] val;
   } exp_t;

   exp_t sbq[$];
   int   ecnt  = 0;
   int   tests = 0;
   int   fails = 0;
   bit   done  = 1'b0;

   localparam logic [15:0] M_ACT = 16'hFE00;
   localparam logic [15:0] M_SOC = 16'h01FE;
   localparam logic [15:0] M_OK  = 16'h0001;
   localparam logic [15:0] M_ALL = 16'hFFFF;

   wire [15:0] obs = {motor_en, engine_start, engine_run, regen_en, fault,
                      active_mode, soc, battery_ok};

   always @(posedge clk) ecnt <= ecnt + 1;

   function automatic logic [15:0] act(input logic mo, st, rn, rg, fl, input logic [1:0] am);
      return {mo, st, rn, rg, fl, am, 9'b0};
   endfunction

   function automatic logic [15:0] socv(input int s, input logic ok);
      return {7'b0, 8'(s), ok};
   endfunction

   task automatic expect_at(input int c, input string nm, input logic [15:0] m, input logic [15:0] v);
      exp_t e;
      e.cyc = c; e.nm = nm; e.mask = m; e.val = v & m;
      sbq.push_back(e);
   endtask

   task automatic wait_to(input int c);
      while (ecnt < c) begin
         @(posedge clk);
         #2;
      end
   endtask

   always @(negedge clk) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].cyc == ecnt) begin
            tests++;
            if ((obs & sbq[i].mask) !== sbq[i].val) begin
               fails++;
               $display("FAIL %s @edge %0d: got %h want %h (mask %h)",
                        sbq[i].nm, ecnt, obs & sbq[i].mask, sbq[i].val, sbq[i].mask);
            end
            sbq.delete(i);
         end else if (sbq[i].cyc < ecnt || done) begin
            tests++;
            fails++;
            $display("FAIL %s never checked (due edge %0d, now %0d)", sbq[i].nm, sbq[i].cyc, ecnt);
            sbq.delete(i);
         end
      end
   end

   initial begin
      int t, r, te, tr, f, g;
      logic [15:0] z;
      z = act(0, 0, 0, 0, 0, 0);

      // reset state
      wait_to(2);
      expect_at(2, "reset_state", M_ALL, z | socv(200, 1));
      wait_to(3); reset_n = 1'b1; r = ecnt;

      // idle -> electric: 4 filter + 1 + 2 dead
      wait_to(r + 2); t = ecnt; m0 = 1'b1;
      expect_at(t + 6, "elec_pre", M_ACT, z);
      expect_at(t + 7, "elec_on",  M_ACT, act(1, 0, 0, 0, 0, 1));

      // electric -> regen: exactly two all-off cycles
      wait_to(t + 10); t = ecnt; m0 = 1'b0; m2 = 1'b1;
      expect_at(t + 4, "e2r_hold",  M_ACT, act(1, 0, 0, 0, 0, 1));
      expect_at(t + 5, "e2r_dead0", M_ACT, z);
      expect_at(t + 6, "e2r_dead1", M_ACT, z);
      expect_at(t + 7, "e2r_regen", M_ACT, act(0, 0, 0, 1, 0, 3));

      wait_to(t + 10); t = ecnt; m2 = 1'b0;
      expect_at(t + 7, "regen_idle", M_ACT, z);

      // hybrid: ready arrives after 5 crank cycles
      wait_to(t + 10); t = ecnt; m1 = 1'b1;
      expect_at(t + 6,  "crank_pre", M_ACT, z);
      expect_at(t + 7,  "crank_on",  M_ACT, act(0, 1, 0, 0, 0, 2));
      expect_at(t + 11, "crank_5th", M_ACT, act(0, 1, 0, 0, 0, 2));
      expect_at(t + 12, "hybrid_on", M_ACT, act(1, 0, 1, 0, 0, 2));
      wait_to(t + 11); rdy = 1'b1;

      // engine_ready drop in hybrid -> fault, then clear via idle
      wait_to(t + 15); t = ecnt; rdy = 1'b0;
      expect_at(t + 1, "ready_drop_fault", M_ACT, act(0, 0, 0, 0, 1, 0));
      wait_to(t + 3); t = ecnt; m1 = 1'b0;
      expect_at(t + 4, "fault_hold",  M_ACT, act(0, 0, 0, 0, 1, 0));
      expect_at(t + 7, "fault_clear", M_ACT, z);

      // crank timeout
      wait_to(t + 10); t = ecnt; m1 = 1'b1;
      expect_at(t + 22, "crank_last",    M_ACT, act(0, 1, 0, 0, 0, 2));
      expect_at(t + 23, "crank_timeout", M_ACT, act(0, 0, 0, 0, 1, 0));
      wait_to(t + 25); t = ecnt; m1 = 1'b0;
      expect_at(t + 7, "timeout_clear", M_ACT, z);

      // asynchronous reset mid-crank
      wait_to(t + 10); t = ecnt; m1 = 1'b1;
      expect_at(t + 8, "crank_again", M_ACT, act(0, 1, 0, 0, 0, 2));
      wait_to(t + 9); reset_n = 1'b0; m1 = 1'b0;
      expect_at(t + 9, "async_reset", M_ALL, z | socv(200, 1));
      wait_to(t + 10); reset_n = 1'b1; r = ecnt;

      // two lines high -> fault with no dead time
      wait_to(r + 3); t = ecnt; m0 = 1'b1; m2 = 1'b1;
      expect_at(t + 4, "inv_pre",   M_ACT, z);
      expect_at(t + 5, "inv_fault", M_ACT, act(0, 0, 0, 0, 1, 0));
      wait_to(t + 8); t = ecnt; m0 = 1'b0; m2 = 1'b0;
      expect_at(t + 4, "inv_hold",  M_ACT, act(0, 0, 0, 0, 1, 0));
      expect_at(t + 7, "inv_clear", M_ACT, z);

      // electric with a 2-cycle glitch, then drain the battery
      wait_to(t + 10); t = ecnt; m0 = 1'b1; te = t + 7;
      f = te + 1;
      while ((f - r) % 4 != 0) f++;
      expect_at(te,     "elec2_on",       M_ACT, act(1, 0, 0, 0, 0, 1));
      expect_at(t + 13, "glitch_a",       M_ACT, act(1, 0, 0, 0, 0, 1));
      expect_at(t + 20, "glitch_b",       M_ACT, act(1, 0, 0, 0, 0, 1));
      expect_at(f - 1,  "soc_start",      M_SOC, socv(200, 0));
      expect_at(f,      "soc_first_tick", M_SOC, socv(199, 0));
      expect_at(f + 544, "soc63_ok_lag",  M_SOC | M_OK, socv(63, 1));
      expect_at(f + 545, "soc63_ok_low",  M_SOC | M_OK, socv(63, 0));
      expect_at(f + 796, "soc_zero",      M_ACT | M_SOC, act(1, 0, 0, 0, 0, 1) | socv(0, 0));
      expect_at(f + 797, "soc_empty_dead", M_ACT, z);
      expect_at(f + 810, "elec_lockout",  M_ACT | M_SOC, z | socv(0, 0));
      wait_to(t + 10); m2 = 1'b1;
      wait_to(t + 12); m2 = 1'b0;

      // switch away to regen releases the lockout; charge and saturate
      wait_to(f + 811); t = ecnt; m0 = 1'b0; m2 = 1'b1; tr = t + 7;
      g = tr + 1;
      while ((g - r) % 4 != 0) g++;
      expect_at(tr,      "lock_release_regen", M_ACT, act(0, 0, 0, 1, 0, 3));
      expect_at(g - 1,   "chg_start",  M_SOC, socv(0, 0));
      expect_at(g,       "chg_first",  M_SOC, socv(2, 0));
      expect_at(g + 156, "soc80_lag",  M_SOC | M_OK, socv(80, 0));
      expect_at(g + 157, "soc80_ok",   M_SOC | M_OK, socv(80, 1));
      expect_at(g + 504, "soc254",     M_SOC, socv(254, 0));
      expect_at(g + 508, "soc_sat",    M_SOC, socv(255, 0));
      expect_at(g + 520, "soc_sat_hold", M_SOC | M_OK, socv(255, 1));
      wait_to(g + 521);

      done = 1'b1;
      @(negedge clk);
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
